// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue/writeback controller around a combinational RV32I ALU.
// Decodes OP/OP-IMM/LUI/AUIPC into ALU operands, captures the result, and presents a writeback packet.
module alu_issue_ctrl (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  output logic [31:0] alu_op_1_out,
  output logic [31:0] alu_op_2_out,
  output logic [3:0]  alu_opcode_out,
  input  logic [31:0] alu_result_in,
  output logic        wb_valid_out,
  input  logic        wb_ready_in,
  output logic [4:0]  wb_rd_out,
  output logic [31:0] wb_data_out,
  output logic        wb_we_out,
  output logic        illegal_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [1:0]  r_state;
  logic [31:0] r_op1, r_op2, r_wb_data;
  logic [3:0]  r_opc;
  logic [4:0]  r_rd, r_wb_rd;
  logic        r_legal, r_wb_we, r_illegal;

  logic [6:0]  w_opcode7, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_u;
  logic [31:0] w_op1, w_op2;
  logic [3:0]  w_opc;
  logic        w_legal;

  assign w_opcode7 = instr_in[6:0];
  assign w_f3      = instr_in[14:12];
  assign w_f7      = instr_in[31:25];
  assign w_imm_i   = {{20{instr_in[31]}}, instr_in[31:20]};
  assign w_imm_u   = {instr_in[31:12], 12'h000};

  always_comb begin
    w_op1   = '0;
    w_op2   = '0;
    w_opc   = 4'b0000;
    w_legal = 1'b0;
    case (w_opcode7)
      OPC_OP: begin
        w_op1   = rs1_data_in;
        w_op2   = rs2_data_in;
        w_opc   = {instr_in[30], w_f3};
        w_legal = (w_f7 == F7_ZERO) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OPC_IMM: begin
        w_op1 = rs1_data_in;
        w_op2 = w_imm_i;
        // Only the right shifts take bit 30 as the arithmetic selector.
        w_opc = (w_f3 == 3'b101) ? {instr_in[30], w_f3} : {1'b0, w_f3};
        case (w_f3)
          3'b001:  w_legal = (w_f7 == F7_ZERO);
          3'b101:  w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          default: w_legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_op2   = w_imm_u;
        w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_op1   = pc_in;
        w_op2   = w_imm_u;
        w_legal = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_op1 = '0;
      w_op2 = '0;
      w_opc = 4'b0000;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= S_IDLE;
      r_op1     <= '0;
      r_op2     <= '0;
      r_opc     <= '0;
      r_rd      <= '0;
      r_legal   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_wb_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid_in) begin
          r_op1   <= w_op1;
          r_op2   <= w_op2;
          r_opc   <= w_opc;
          r_rd    <= instr_in[11:7];
          r_legal <= w_legal;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_wb_rd   <= r_rd;
          r_wb_data <= r_legal ? alu_result_in : 32'h0;
          r_wb_we   <= r_legal && (r_rd != 5'd0);
          r_illegal <= !r_legal;
          r_state   <= S_RESP;
        end
        S_RESP: if (wb_ready_in) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready_out = (r_state == S_IDLE);
  assign wb_valid_out    = (r_state == S_RESP);
  assign alu_op_1_out    = r_op1;
  assign alu_op_2_out    = r_op2;
  assign alu_opcode_out  = r_opc;
  assign wb_rd_out       = r_wb_rd;
  assign wb_data_out     = r_wb_data;
  assign wb_we_out       = r_wb_we;
  assign illegal_out     = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: external ALU model, instruction-semantics reference model,
// per-cycle compare process, and directed vectors with literal expected results.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic [31:0] instr_in, pc_in, rs1_data_in, rs2_data_in;
  logic [31:0] alu_op_1_out, alu_op_2_out;
  logic [3:0]  alu_opcode_out;
  logic [31:0] alu_result_in;
  logic        wb_valid_out, wb_ready_in;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic        wb_we_out, illegal_out;

  alu_issue_ctrl dut (
    .clk_in(clk), .rst_n_in(rst_n_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .instr_in(instr_in), .pc_in(pc_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .alu_op_1_out(alu_op_1_out), .alu_op_2_out(alu_op_2_out),
    .alu_opcode_out(alu_opcode_out), .alu_result_in(alu_result_in),
    .wb_valid_out(wb_valid_out), .wb_ready_in(wb_ready_in),
    .wb_rd_out(wb_rd_out), .wb_data_out(wb_data_out),
    .wb_we_out(wb_we_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  // The combinational ALU this block drives.
  always_comb begin
    case (alu_opcode_out)
      4'b0000: alu_result_in = alu_op_1_out + alu_op_2_out;
      4'b1000: alu_result_in = alu_op_1_out - alu_op_2_out;
      4'b0001: alu_result_in = alu_op_1_out << alu_op_2_out[4:0];
      4'b0010: alu_result_in = {31'h0, $signed(alu_op_1_out) < $signed(alu_op_2_out)};
      4'b0011: alu_result_in = {31'h0, alu_op_1_out < alu_op_2_out};
      4'b0100: alu_result_in = alu_op_1_out ^ alu_op_2_out;
      4'b0101: alu_result_in = alu_op_1_out >> alu_op_2_out[4:0];
      4'b1101: alu_result_in = $unsigned($signed(alu_op_1_out) >>> alu_op_2_out[4:0]);
      4'b0110: alu_result_in = alu_op_1_out | alu_op_2_out;
      4'b0111: alu_result_in = alu_op_1_out & alu_op_2_out;
      default: alu_result_in = 32'h0;
    endcase
  end

  typedef struct {
    logic [31:0] op1, op2, data;
    logic [3:0]  opc;
    logic [4:0]  rd;
    logic        we, ill;
  } pkt_t;

  // What an instruction must do, from its RV32I meaning.
  function automatic pkt_t model(input logic [31:0] ins, pc, a, b);
    pkt_t p;
    logic [31:0] y;
    logic alt, ok;
    logic [2:0] f3;
    logic [6:0] f7;
    p = '{default: '0};
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b1;
    alt = 1'b0;
    y = b;
    case (ins[6:0])
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        alt = ins[30];
      end
      7'h13: begin
        y = {{20{ins[31]}}, ins[31:20]};
        alt = (f3 == 3'd5) && ins[30];
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h37, 7'h17: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
      p.op1 = (ins[6:0] == 7'h17) ? pc : 32'h0;
      p.op2 = {ins[31:12], 12'h000};
      p.data = p.op1 + p.op2;
    end else if (ok) begin
      p.op1 = a;
      p.op2 = y;
      p.opc = {alt, f3};
      case (f3)
        3'd0: p.data = alt ? a - y : a + y;
        3'd1: p.data = a << y[4:0];
        3'd2: p.data = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: p.data = (a < y) ? 32'd1 : 32'd0;
        3'd4: p.data = a ^ y;
        3'd5: p.data = alt ? $unsigned($signed(a) >>> y[4:0]) : a >> y[4:0];
        3'd6: p.data = a | y;
        default: p.data = a & y;
      endcase
    end
    p.rd = ins[11:7];
    p.ill = !ok;
    p.we = ok && (p.rd != 5'd0);
    return p;
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Transaction tracker: what packet is in flight and when it was accepted.
  logic pending = 1'b0;
  pkt_t exp_p;
  int cyc = 0;
  int acc = 0;

  always @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!pending && instr_valid_in && instr_ready_out) begin
        pending <= 1'b1;
        exp_p <= model(instr_in, pc_in, rs1_data_in, rs2_data_in);
        acc <= cyc + 1;
      end else if (pending && wb_valid_out && wb_ready_in) begin
        pending <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n_in) begin
      chk("rst_ready", instr_ready_out, 1);
      chk("rst_wb_valid", wb_valid_out, 0);
      chk("rst_alu", {alu_op_1_out | alu_op_2_out}, 0);
      chk("rst_pkt", {wb_data_out[31:7], wb_rd_out, wb_we_out, illegal_out, alu_opcode_out}, 0);
    end else begin
      chk("ready", instr_ready_out, !pending);
      chk("wb_valid", wb_valid_out, pending && (cyc > acc));
      if (pending) begin
        chk("alu_op1", alu_op_1_out, exp_p.op1);
        chk("alu_op2", alu_op_2_out, exp_p.op2);
        chk("alu_opcode", alu_opcode_out, exp_p.opc);
      end
      if (pending && wb_valid_out) begin
        chk("wb_rd", wb_rd_out, exp_p.rd);
        chk("wb_data", wb_data_out, exp_p.data);
        chk("wb_we", wb_we_out, exp_p.we);
        chk("illegal", illegal_out, exp_p.ill);
      end
    end
  end

  task automatic issue(input string nm, input logic [31:0] ins, pc, a, b, xd,
                       input logic xwe, xill, input int hold);
    int n;
    @(posedge clk); #2;
    instr_valid_in = 1'b1;
    instr_in = ins; pc_in = pc; rs1_data_in = a; rs2_data_in = b;
    wb_ready_in = (hold == 0);
    n = 0;
    while (!instr_ready_out && n < 20) begin @(posedge clk); #2; n++; end
    @(posedge clk); #2;
    // Scramble source inputs: the block must work from what it captured.
    instr_valid_in = 1'b0;
    instr_in = $urandom; pc_in = $urandom; rs1_data_in = $urandom; rs2_data_in = $urandom;
    n = 0;
    while (!wb_valid_out && n < 8) begin @(posedge clk); #2; n++; end
    chk({nm, "_in_time"}, n < 8, 1);
    chk({nm, "_data"}, wb_data_out, xd);
    chk({nm, "_we"}, wb_we_out, xwe);
    chk({nm, "_illegal"}, illegal_out, xill);
    repeat (hold) begin
      @(posedge clk); #2;
      chk({nm, "_hold_valid"}, wb_valid_out, 1);
      chk({nm, "_hold_ready"}, instr_ready_out, 0);
      chk({nm, "_hold_data"}, wb_data_out, xd);
    end
    wb_ready_in = 1'b1;
    @(posedge clk); #2;
    chk({nm, "_done"}, wb_valid_out, 0);
  endtask

  initial begin
    int n;
    rst_n_in = 1'b0;
    instr_valid_in = 1'b0;
    wb_ready_in = 1'b0;
    instr_in = '0; pc_in = '0; rs1_data_in = '0; rs2_data_in = '0;
    repeat (4) begin
      @(posedge clk); #2;
      instr_valid_in = 1'($urandom); wb_ready_in = 1'($urandom);
      instr_in = $urandom; pc_in = $urandom; rs1_data_in = $urandom; rs2_data_in = $urandom;
    end
    instr_valid_in = 1'b0; wb_ready_in = 1'b1;
    rst_n_in = 1'b1;
    #1;
    chk("reset_ready", instr_ready_out, 1);
    chk("reset_valid", wb_valid_out, 0);
    chk("reset_data", wb_data_out, 0);

    issue("add",   32'h002082B3, 0, 32'h1, 32'h1, 32'h2, 1, 0, 0);
    chk("add_rd", wb_rd_out, 5);
    issue("sub",   32'h402082B3, 0, 32'h2, 32'h1, 32'h1, 1, 0, 0);
    issue("addi",  32'hFFF00193, 0, 32'h0, 32'h5, 32'hFFFFFFFF, 1, 0, 0);
    issue("srai",  32'h4040D213, 0, 32'h80000000, 32'h0, 32'hF8000000, 1, 0, 0);
    issue("lui",   32'h123453B7, 0, 32'h5, 32'h6, 32'h12345000, 1, 0, 0);
    issue("auipc", 32'h00001397, 32'h100, 32'h5, 32'h6, 32'h00001100, 1, 0, 0);
    issue("load",  32'h0000A083, 0, 32'h5, 32'h6, 32'h0, 0, 1, 0);
    issue("addx0", 32'h00208033, 0, 32'h3, 32'h4, 32'h7, 0, 0, 0);
    issue("slt",   32'h0020A2B3, 0, 32'hFFFFFFFF, 32'h1, 32'h1, 1, 0, 0);
    issue("sltu",  32'h0020B2B3, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0);
    issue("xori",  32'hFFF0C193, 0, 32'h0F0F0F0F, 32'h0, 32'hF0F0F0F0, 1, 0, 0);
    issue("slli",  32'h01F09193, 0, 32'h1, 32'h0, 32'h80000000, 1, 0, 0);
    issue("srl",   32'h0020D2B3, 0, 32'h80000000, 32'h21, 32'h40000000, 1, 0, 0);
    issue("badop", 32'h402092B3, 0, 32'h1, 32'h1, 32'h0, 0, 1, 0);
    issue("badsll",32'h40409213, 0, 32'h1, 32'h1, 32'h0, 0, 1, 0);
    issue("or_bp", 32'h0020E2B3, 0, 32'hF0, 32'h0F, 32'hFF, 1, 0, 5);

    // Source holds valid through EXEC/RESP; the second packet waits its turn.
    @(posedge clk); #2;
    instr_valid_in = 1'b1; instr_in = 32'h0020C2B3; rs1_data_in = 32'hFF00; rs2_data_in = 32'h0FF0;
    @(posedge clk); #2;
    instr_in = 32'h0020F2B3; rs1_data_in = 32'hFF00; rs2_data_in = 32'h0FF0;
    n = 0;
    while (!instr_ready_out && n < 10) begin @(posedge clk); #2; n++; end
    chk("b2b_interval", n, 2);
    @(posedge clk); #2;
    instr_valid_in = 1'b0;
    @(posedge clk); #2;
    chk("b2b_and", wb_data_out, 32'h0F00);
    @(posedge clk); #2;

    // Reset during EXEC aborts the packet.
    instr_valid_in = 1'b1; instr_in = 32'h002082B3; rs1_data_in = 32'h9; rs2_data_in = 32'h9;
    @(posedge clk); #2;
    instr_valid_in = 1'b0;
    chk("abort_in_exec", instr_ready_out, 0);
    rst_n_in = 1'b0;
    #1;
    chk("abort_ready", instr_ready_out, 1);
    chk("abort_alu_op1", alu_op_1_out, 0);
    chk("abort_alu_op2", alu_op_2_out, 0);
    chk("abort_opcode", alu_opcode_out, 0);
    @(posedge clk); #2;
    rst_n_in = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      chk("abort_no_wb", wb_valid_out, 0);
    end
    issue("after_rst", 32'h002082B3, 0, 32'h10, 32'h20, 32'h30, 1, 0, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
